// File: rtl/eth_pkg.sv
// Shared Ethernet header definitions for the receive deframer.
package eth_pkg;

    localparam int unsigned ETH_HDR_BYTES = 14;
    localparam int unsigned MAC_W         = 48;
    localparam int unsigned TYPE_W        = 16;
    localparam int unsigned HDR_W         = ETH_HDR_BYTES * 8;

    // Field order matches wire order, so the 14-byte shift register casts straight onto it.
    typedef struct packed {
        logic [MAC_W-1:0]  dest_mac;
        logic [MAC_W-1:0]  src_mac;
        logic [TYPE_W-1:0] eth_type;
    } eth_hdr_t;

    typedef enum logic {
        ST_HEADER  = 1'b0,
        ST_PAYLOAD = 1'b1
    } rx_state_t;

endpackage

// File: rtl/eth_axis_rx_core.sv
// Ethernet receive deframer: strips the 14-byte header onto a valid/ready
// header channel and forwards the payload through a one-deep register slice.
module eth_axis_rx_core
    import eth_pkg::*;
#(
    parameter int unsigned DATA_WIDTH  = 8,
    parameter bit          KEEP_ENABLE = (DATA_WIDTH > 8),
    parameter int unsigned KEEP_WIDTH  = DATA_WIDTH / 8
) (
    input  logic                  clk,
    input  logic                  reset,

    input  logic [DATA_WIDTH-1:0] s_axis_tdata,
    input  logic [KEEP_WIDTH-1:0] s_axis_tkeep,
    input  logic                  s_axis_tvalid,
    output logic                  s_axis_tready,
    input  logic                  s_axis_tlast,
    input  logic                  s_axis_tuser,

    output logic                  m_eth_hdr_valid,
    input  logic                  m_eth_hdr_ready,
    output logic [MAC_W-1:0]      m_eth_dest_mac,
    output logic [MAC_W-1:0]      m_eth_src_mac,
    output logic [TYPE_W-1:0]     m_eth_type,

    output logic [DATA_WIDTH-1:0] m_eth_payload_axis_tdata,
    output logic [KEEP_WIDTH-1:0] m_eth_payload_axis_tkeep,
    output logic                  m_eth_payload_axis_tvalid,
    input  logic                  m_eth_payload_axis_tready,
    output logic                  m_eth_payload_axis_tlast,
    output logic                  m_eth_payload_axis_tuser,

    output logic                  busy,
    output logic                  error_header_early_termination
);

    localparam int unsigned CNT_W = 4;

    rx_state_t             state;
    logic [CNT_W-1:0]      byte_cnt;
    logic [HDR_W-1:0]      hdr_shift;
    logic [HDR_W-1:0]      hdr_next;
    eth_hdr_t              hdr_q;
    logic                  hdr_valid_q;
    logic [DATA_WIDTH-1:0] pl_data_q;
    logic [KEEP_WIDTH-1:0] pl_keep_q;
    logic                  pl_valid_q;
    logic                  pl_last_q;
    logic                  pl_user_q;
    logic                  busy_q;
    logic                  err_q;
    logic                  accept;
    logic                  hdr_done;
    logic [KEEP_WIDTH-1:0] keep_in;
    logic                  unused_keep;

    // Header side stalls while a header is unconsumed; payload side is a skid-free slice.
    assign s_axis_tready = (state == ST_HEADER) ? !hdr_valid_q
                                                : (!pl_valid_q || m_eth_payload_axis_tready);
    assign accept      = s_axis_tvalid && s_axis_tready;
    assign keep_in     = KEEP_ENABLE ? s_axis_tkeep : '1;
    assign hdr_done    = (byte_cnt == CNT_W'(ETH_HDR_BYTES - KEEP_WIDTH));
    assign unused_keep = ^s_axis_tkeep;

    // Shift beat bytes in arrival order; tdata[7:0] is the earlier byte.
    always_comb begin
        hdr_next = hdr_shift;
        for (int unsigned i = 0; i < KEEP_WIDTH; i++) begin
            hdr_next = {hdr_next[HDR_W-9:0], s_axis_tdata[i*8 +: 8]};
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state       <= ST_HEADER;
            byte_cnt    <= '0;
            hdr_shift   <= '0;
            hdr_q       <= '0;
            hdr_valid_q <= 1'b0;
            pl_data_q   <= '0;
            pl_keep_q   <= '0;
            pl_valid_q  <= 1'b0;
            pl_last_q   <= 1'b0;
            pl_user_q   <= 1'b0;
            busy_q      <= 1'b0;
            err_q       <= 1'b0;
        end else begin
            err_q <= 1'b0;
            if (hdr_valid_q && m_eth_hdr_ready) begin
                hdr_valid_q <= 1'b0;
            end
            if (pl_valid_q && m_eth_payload_axis_tready) begin
                pl_valid_q <= 1'b0;
            end
            if (accept) begin
                busy_q <= !s_axis_tlast;
            end

            case (state)
                ST_HEADER: begin
                    if (accept) begin
                        hdr_shift <= hdr_next;
                        if (s_axis_tlast) begin
                            err_q    <= 1'b1;
                            byte_cnt <= '0;
                        end else if (hdr_done) begin
                            hdr_q       <= eth_hdr_t'(hdr_next);
                            hdr_valid_q <= 1'b1;
                            byte_cnt    <= '0;
                            state       <= ST_PAYLOAD;
                        end else begin
                            byte_cnt <= byte_cnt + CNT_W'(KEEP_WIDTH);
                        end
                    end
                end
                ST_PAYLOAD: begin
                    if (accept) begin
                        pl_data_q  <= s_axis_tdata;
                        pl_keep_q  <= keep_in;
                        pl_last_q  <= s_axis_tlast;
                        pl_user_q  <= s_axis_tuser;
                        pl_valid_q <= 1'b1;
                        if (s_axis_tlast) begin
                            state <= ST_HEADER;
                        end
                    end
                end
                default: state <= ST_HEADER;
            endcase
        end
    end

    assign m_eth_hdr_valid                = hdr_valid_q;
    assign m_eth_dest_mac                 = hdr_q.dest_mac;
    assign m_eth_src_mac                  = hdr_q.src_mac;
    assign m_eth_type                     = hdr_q.eth_type;
    assign m_eth_payload_axis_tdata       = pl_data_q;
    assign m_eth_payload_axis_tkeep       = pl_keep_q;
    assign m_eth_payload_axis_tvalid      = pl_valid_q;
    assign m_eth_payload_axis_tlast       = pl_last_q;
    assign m_eth_payload_axis_tuser       = pl_user_q;
    assign busy                           = busy_q;
    assign error_header_early_termination = err_q;

endmodule

// File: tb/tb_eth_axis_rx_core.sv
// Directed bench for eth_axis_rx_core: an 8-bit instance for most scenarios
// and a 16-bit keep-enabled instance for beat packing.
module tb_eth_axis_rx_core;

    typedef logic [7:0] byteq_t[$];

    localparam logic [111:0] H1 = {48'h020000000001, 48'h020000000002, 16'h0800};
    localparam logic [111:0] H2 = {48'hFFFFFFFFFFFF, 48'h001122334455, 16'h0806};
    localparam logic [111:0] H3 = {48'h0A0B0C0D0E0F, 48'h101112131415, 16'h86DD};
    localparam logic [111:0] H4 = {48'h3C3C3C3C3C3C, 48'hC3C3C3C3C3C3, 16'h8100};

    logic clk = 1'b0;
    logic reset = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int fails  = 0;

    // 8-bit instance signals
    logic [7:0]  s8_tdata = '0;
    logic [0:0]  s8_tkeep = '0;
    logic        s8_tvalid = 1'b0, s8_tready, s8_tlast = 1'b0, s8_tuser = 1'b0;
    logic        m8_hdr_valid, hdr_ready8 = 1'b1;
    logic [47:0] m8_dest, m8_src;
    logic [15:0] m8_type;
    logic [7:0]  m8_tdata;
    logic [0:0]  m8_tkeep;
    logic        m8_tvalid, pl_ready8 = 1'b1, m8_tlast, m8_tuser;
    logic        m8_busy, m8_err;

    // 16-bit instance signals
    logic [15:0] s16_tdata = '0;
    logic [1:0]  s16_tkeep = '0;
    logic        s16_tvalid = 1'b0, s16_tready, s16_tlast = 1'b0, s16_tuser = 1'b0;
    logic        m16_hdr_valid, hdr_ready16 = 1'b1;
    logic [47:0] m16_dest, m16_src;
    logic [15:0] m16_type;
    logic [15:0] m16_tdata;
    logic [1:0]  m16_tkeep;
    logic        m16_tvalid, pl_ready16 = 1'b1, m16_tlast, m16_tuser;
    logic        m16_busy, m16_err;

    logic pl_rand = 1'b0;
    logic pl_hold = 1'b0;

    logic [111:0] hq8[$];
    logic [10:0]  pq8[$];     // {user, last, keep, data}
    logic [111:0] hq16[$];
    logic [19:0]  pq16[$];    // {user, last, keep[1:0], data[15:0]}
    int err8 = 0;
    int busy_hi8 = 0;

    eth_axis_rx_core #(.DATA_WIDTH(8)) dut8 (
        .clk(clk), .reset(reset),
        .s_axis_tdata(s8_tdata), .s_axis_tkeep(s8_tkeep), .s_axis_tvalid(s8_tvalid),
        .s_axis_tready(s8_tready), .s_axis_tlast(s8_tlast), .s_axis_tuser(s8_tuser),
        .m_eth_hdr_valid(m8_hdr_valid), .m_eth_hdr_ready(hdr_ready8),
        .m_eth_dest_mac(m8_dest), .m_eth_src_mac(m8_src), .m_eth_type(m8_type),
        .m_eth_payload_axis_tdata(m8_tdata), .m_eth_payload_axis_tkeep(m8_tkeep),
        .m_eth_payload_axis_tvalid(m8_tvalid), .m_eth_payload_axis_tready(pl_ready8),
        .m_eth_payload_axis_tlast(m8_tlast), .m_eth_payload_axis_tuser(m8_tuser),
        .busy(m8_busy), .error_header_early_termination(m8_err)
    );

    eth_axis_rx_core #(.DATA_WIDTH(16)) dut16 (
        .clk(clk), .reset(reset),
        .s_axis_tdata(s16_tdata), .s_axis_tkeep(s16_tkeep), .s_axis_tvalid(s16_tvalid),
        .s_axis_tready(s16_tready), .s_axis_tlast(s16_tlast), .s_axis_tuser(s16_tuser),
        .m_eth_hdr_valid(m16_hdr_valid), .m_eth_hdr_ready(hdr_ready16),
        .m_eth_dest_mac(m16_dest), .m_eth_src_mac(m16_src), .m_eth_type(m16_type),
        .m_eth_payload_axis_tdata(m16_tdata), .m_eth_payload_axis_tkeep(m16_tkeep),
        .m_eth_payload_axis_tvalid(m16_tvalid), .m_eth_payload_axis_tready(pl_ready16),
        .m_eth_payload_axis_tlast(m16_tlast), .m_eth_payload_axis_tuser(m16_tuser),
        .busy(m16_busy), .error_header_early_termination(m16_err)
    );

    // Payload ready pattern, updated just after each rising edge.
    always @(posedge clk) begin
        #1;
        if (pl_hold) pl_ready8 = 1'b0;
        else if (pl_rand) pl_ready8 = 1'($urandom_range(0, 1));
        else pl_ready8 = 1'b1;
    end

    // Handshakes are stable between the falling and next rising edge.
    always @(negedge clk) begin
        if (reset) begin
            if (m8_hdr_valid && hdr_ready8) hq8.push_back({m8_dest, m8_src, m8_type});
            if (m8_tvalid && pl_ready8) pq8.push_back({m8_tuser, m8_tlast, m8_tkeep, m8_tdata});
            if (m8_err) err8++;
            if (m8_busy) busy_hi8++;
            if (m16_hdr_valid && hdr_ready16) hq16.push_back({m16_dest, m16_src, m16_type});
            if (m16_tvalid && pl_ready16) pq16.push_back({m16_tuser, m16_tlast, m16_tkeep, m16_tdata});
        end
    end

    function automatic byteq_t hdr_bytes(input logic [111:0] h);
        byteq_t q;
        for (int i = 0; i < 14; i++) q.push_back(h[111-8*i -: 8]);
        return q;
    endfunction

    task automatic clear_obs();
        hq8.delete(); pq8.delete(); hq16.delete(); pq16.delete();
        err8 = 0; busy_hi8 = 0;
    endtask

    task automatic send8(input logic [7:0] d, input logic last, input logic user);
        int n = 0;
        s8_tdata = d; s8_tlast = last; s8_tuser = user; s8_tvalid = 1'b1;
        @(negedge clk);
        while (!s8_tready && n < 500) begin n++; @(negedge clk); end
        if (!s8_tready) begin
            checks++; fails++;
            $display("FAIL send8_timeout: tready=%b required 1", s8_tready);
        end
        @(posedge clk); #1;
        s8_tvalid = 1'b0; s8_tlast = 1'b0; s8_tuser = 1'b0;
    endtask

    task automatic send_frame8(input byteq_t b, input bit with_last, input bit user_hdr, input bit user_last);
        for (int i = 0; i < b.size(); i++) begin
            if (i == b.size() - 1) send8(b[i], with_last, user_last);
            else if (i < 14) send8(b[i], 1'b0, user_hdr);
            else send8(b[i], 1'b0, 1'b0);
        end
    endtask

    task automatic send16(input logic [15:0] d, input logic [1:0] k, input logic last);
        int n = 0;
        s16_tdata = d; s16_tkeep = k; s16_tlast = last; s16_tvalid = 1'b1;
        @(negedge clk);
        while (!s16_tready && n < 500) begin n++; @(negedge clk); end
        if (!s16_tready) begin
            checks++; fails++;
            $display("FAIL send16_timeout: tready=%b required 1", s16_tready);
        end
        @(posedge clk); #1;
        s16_tvalid = 1'b0; s16_tlast = 1'b0;
    endtask

    task automatic wait_pl8(input int n);
        int k = 0;
        while (pq8.size() < n && k < 2000) begin @(posedge clk); #1; k++; end
        repeat (3) @(posedge clk);
        #1;
        checks++;
        if (pq8.size() != n) begin
            fails++;
            $display("FAIL payload8_count: got %0d beats required %0d", pq8.size(), n);
        end
    endtask

    task automatic check_pl8(input string name, input int idx, input logic [7:0] d, input logic last, input logic user);
        logic [10:0] got, exp;
        got = (idx < pq8.size()) ? pq8[idx] : 'x;
        exp = {user, last, 1'b1, d};
        checks++;
        if (got !== exp) begin
            fails++;
            $display("FAIL %s[%0d]: got %h required %h", name, idx, got, exp);
        end
    endtask

    task automatic check_hdr8(input string name, input int idx, input logic [111:0] exp);
        logic [111:0] got;
        got = (idx < hq8.size()) ? hq8[idx] : 'x;
        checks++;
        if (got !== exp) begin
            fails++;
            $display("FAIL %s[%0d]: got %h required %h", name, idx, got, exp);
        end
    endtask

    task automatic test_reset();
        repeat (3) @(posedge clk);
        @(negedge clk);
        checks++; if (m8_hdr_valid !== 1'b0) begin fails++; $display("FAIL reset_hdr_valid: got %b required 0", m8_hdr_valid); end
        checks++; if (m8_tvalid !== 1'b0) begin fails++; $display("FAIL reset_pl_valid: got %b required 0", m8_tvalid); end
        checks++; if (m8_busy !== 1'b0) begin fails++; $display("FAIL reset_busy: got %b required 0", m8_busy); end
        checks++; if (m8_err !== 1'b0) begin fails++; $display("FAIL reset_error: got %b required 0", m8_err); end
        checks++; if ({m8_dest, m8_src, m8_type, m8_tdata} !== '0) begin fails++; $display("FAIL reset_regs: got %h required 0", {m8_dest, m8_src, m8_type, m8_tdata}); end
        @(posedge clk); #1;
        reset = 1'b1;
        @(posedge clk); #1;
        @(negedge clk);
        checks++; if (s8_tready !== 1'b1) begin fails++; $display("FAIL reset_tready: got %b required 1", s8_tready); end
        @(posedge clk); #1;
    endtask

    task automatic test_basic();
        byteq_t f;
        clear_obs();
        f = hdr_bytes(H1);
        f.push_back(8'hAA); f.push_back(8'hBB); f.push_back(8'hCC); f.push_back(8'hDD);
        send_frame8(f, 1'b1, 1'b0, 1'b0);
        wait_pl8(4);
        checks++; if (hq8.size() != 1) begin fails++; $display("FAIL basic_hdr_count: got %0d required 1", hq8.size()); end
        check_hdr8("basic_hdr", 0, H1);
        check_pl8("basic_pl", 0, 8'hAA, 1'b0, 1'b0);
        check_pl8("basic_pl", 1, 8'hBB, 1'b0, 1'b0);
        check_pl8("basic_pl", 2, 8'hCC, 1'b0, 1'b0);
        check_pl8("basic_pl", 3, 8'hDD, 1'b1, 1'b0);
        checks++; if (err8 != 0) begin fails++; $display("FAIL basic_error: got %0d cycles required 0", err8); end
        checks++; if (busy_hi8 < 17) begin fails++; $display("FAIL basic_busy_cycles: got %0d required >=17", busy_hi8); end
    endtask

    task automatic test_early_term();
        byteq_t f, full;
        clear_obs();
        full = hdr_bytes(H1);
        for (int i = 0; i < 10; i++) f.push_back(full[i]);
        send_frame8(f, 1'b1, 1'b0, 1'b0);
        repeat (4) @(posedge clk);
        #1;
        @(negedge clk);
        checks++; if (err8 != 1) begin fails++; $display("FAIL early_err_cycles: got %0d required 1", err8); end
        checks++; if (hq8.size() != 0 || m8_hdr_valid !== 1'b0) begin fails++; $display("FAIL early_no_hdr: got %0d/%b required 0/0", hq8.size(), m8_hdr_valid); end
        checks++; if (pq8.size() != 0) begin fails++; $display("FAIL early_no_payload: got %0d required 0", pq8.size()); end
        checks++; if (m8_busy !== 1'b0) begin fails++; $display("FAIL early_busy: got %b required 0", m8_busy); end
        @(posedge clk); #1;
        f = hdr_bytes(H2); f.push_back(8'h12); f.push_back(8'h34);
        send_frame8(f, 1'b1, 1'b0, 1'b0);
        wait_pl8(2);
        check_hdr8("early_next_hdr", 0, H2);
        check_pl8("early_next_pl", 0, 8'h12, 1'b0, 1'b0);
        check_pl8("early_next_pl", 1, 8'h34, 1'b1, 1'b0);
        checks++; if (err8 != 1) begin fails++; $display("FAIL early_next_err: got %0d required 1", err8); end
    endtask

    task automatic test_hdr_backpressure();
        byteq_t f1, f2;
        clear_obs();
        hdr_ready8 = 1'b0;
        f1 = hdr_bytes(H3); f1.push_back(8'h11); f1.push_back(8'h22);
        f2 = hdr_bytes(H4); f2.push_back(8'h33); f2.push_back(8'h44);
        send_frame8(f1, 1'b1, 1'b0, 1'b0);
        wait_pl8(2);
        repeat (20) @(posedge clk);
        #1;
        @(negedge clk);
        checks++; if (m8_hdr_valid !== 1'b1) begin fails++; $display("FAIL hbp_valid_held: got %b required 1", m8_hdr_valid); end
        checks++; if ({m8_dest, m8_src, m8_type} !== H3) begin fails++; $display("FAIL hbp_fields_stable: got %h required %h", {m8_dest, m8_src, m8_type}, H3); end
        @(posedge clk); #1;
        s8_tdata = f2[0]; s8_tvalid = 1'b1;
        @(negedge clk);
        checks++; if (s8_tready !== 1'b0) begin fails++; $display("FAIL hbp_tready_blocked: got %b required 0", s8_tready); end
        @(posedge clk); #1;
        fork
            send_frame8(f2, 1'b1, 1'b0, 1'b0);
            begin repeat (3) @(posedge clk); #1; hdr_ready8 = 1'b1; end
        join
        wait_pl8(4);
        checks++; if (hq8.size() != 2) begin fails++; $display("FAIL hbp_hdr_count: got %0d required 2", hq8.size()); end
        check_hdr8("hbp_hdr", 0, H3);
        check_hdr8("hbp_hdr", 1, H4);
        check_pl8("hbp_pl", 2, 8'h33, 1'b0, 1'b0);
        check_pl8("hbp_pl", 3, 8'h44, 1'b1, 1'b0);
    endtask

    task automatic test_payload_backpressure();
        byteq_t f;
        clear_obs();
        pl_rand = 1'b1;
        f = hdr_bytes(H2);
        for (int i = 0; i < 64; i++) f.push_back(8'(i * 3 + 5));
        send_frame8(f, 1'b1, 1'b0, 1'b0);
        wait_pl8(64);
        pl_rand = 1'b0;
        for (int i = 0; i < 64; i++) check_pl8("pbp_pl", i, 8'(i * 3 + 5), (i == 63), 1'b0);
        check_hdr8("pbp_hdr", 0, H2);
        @(negedge clk);
        checks++; if (m8_busy !== 1'b0) begin fails++; $display("FAIL pbp_busy_after: got %b required 0", m8_busy); end
        @(posedge clk); #1;
    endtask

    task automatic test_tuser();
        byteq_t f;
        clear_obs();
        f = hdr_bytes(H1);
        f.push_back(8'h01); f.push_back(8'h02); f.push_back(8'h03);
        send_frame8(f, 1'b1, 1'b1, 1'b1);
        wait_pl8(3);
        check_pl8("tuser_pl", 0, 8'h01, 1'b0, 1'b0);
        check_pl8("tuser_pl", 1, 8'h02, 1'b0, 1'b0);
        check_pl8("tuser_pl", 2, 8'h03, 1'b1, 1'b1);
    endtask

    task automatic test_reset_midframe();
        byteq_t f;
        clear_obs();
        pl_hold = 1'b1;
        f = hdr_bytes(H2); f.push_back(8'h5A);
        send_frame8(f, 1'b0, 1'b0, 1'b0);
        repeat (2) @(posedge clk);
        #1;
        @(negedge clk);
        checks++; if (m8_busy !== 1'b1 || m8_tvalid !== 1'b1) begin fails++; $display("FAIL midrst_pre: got busy=%b valid=%b required 1/1", m8_busy, m8_tvalid); end
        #2; reset = 1'b0; #1;
        checks++; if (m8_busy !== 1'b0 || m8_tvalid !== 1'b0 || m8_hdr_valid !== 1'b0) begin
            fails++; $display("FAIL midrst_immediate: got busy=%b valid=%b hdr=%b required 0/0/0", m8_busy, m8_tvalid, m8_hdr_valid);
        end
        @(posedge clk); #1;
        reset = 1'b1; pl_hold = 1'b0;
        @(posedge clk); #1;
        clear_obs();
        f = hdr_bytes(H4); f.push_back(8'h77);
        send_frame8(f, 1'b1, 1'b0, 1'b0);
        wait_pl8(1);
        check_hdr8("midrst_next_hdr", 0, H4);
        check_pl8("midrst_next_pl", 0, 8'h77, 1'b1, 1'b0);
    endtask

    task automatic test_width16();
        byteq_t h;
        logic [19:0] got;
        int k = 0;
        clear_obs();
        h = hdr_bytes(H1);
        for (int i = 0; i < 7; i++) send16({h[2*i+1], h[2*i]}, 2'b11, 1'b0);
        send16(16'hBBAA, 2'b11, 1'b0);
        send16(16'h00CC, 2'b01, 1'b1);
        while (pq16.size() < 2 && k < 200) begin @(posedge clk); #1; k++; end
        repeat (2) @(posedge clk);
        #1;
        checks++; if (pq16.size() != 2) begin fails++; $display("FAIL w16_count: got %0d required 2", pq16.size()); end
        got = (hq16.size() > 0) ? hq16[0][19:0] : 'x;
        checks++; if (hq16.size() != 1 || hq16[0] !== H1) begin fails++; $display("FAIL w16_hdr: got %0d headers, low bits %h required 1 and %h", hq16.size(), got, H1[19:0]); end
        got = (pq16.size() > 0) ? pq16[0] : 'x;
        checks++; if (got !== {1'b0, 1'b0, 2'b11, 16'hBBAA}) begin fails++; $display("FAIL w16_beat0: got %h required %h", got, {1'b0, 1'b0, 2'b11, 16'hBBAA}); end
        got = (pq16.size() > 1) ? pq16[1] : 'x;
        checks++; if (got !== {1'b0, 1'b1, 2'b01, 16'h00CC}) begin fails++; $display("FAIL w16_beat1: got %h required %h", got, {1'b0, 1'b1, 2'b01, 16'h00CC}); end
        checks++; if (m16_err !== 1'b0 || m16_busy !== 1'b0) begin fails++; $display("FAIL w16_idle: got err=%b busy=%b required 0/0", m16_err, m16_busy); end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_basic();
        test_early_term();
        test_hdr_backpressure();
        test_payload_backpressure();
        test_tuser();
        test_width16();
        test_reset_midframe();
        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

endmodule
